// File: rtl/fetch_pc_sched.sv
// rtl/fetch_pc_sched.sv - per-warp fetch sequencer with round-robin icache fetch arbiter
module fetch_pc_sched #(
  parameter int NUM_WARP   = 8,
  parameter int DEPTH_WARP = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_valid_i,
  input  logic [DEPTH_WARP-1:0]   init_wid_i,
  input  logic                    end_valid_i,
  input  logic [DEPTH_WARP-1:0]   end_wid_i,
  input  logic                    branch_valid_i,
  input  logic [DEPTH_WARP-1:0]   branch_wid_i,
  input  logic [NUM_WARP-1:0]     stall_i,
  output logic                    fetch_valid_o,
  output logic [DEPTH_WARP-1:0]   fetch_wid_o,
  input  logic                    fetch_ready_i,
  input  logic                    rsp_valid_i,
  input  logic [DEPTH_WARP-1:0]   rsp_wid_i,
  input  logic                    rsp_hit_i,
  output logic [2*NUM_WARP-1:0]   pc_src_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RDY   = 3'd1,
    S_UPD   = 3'd2,
    S_PEND  = 3'd3,
    S_FLUSH = 3'd4
  } warp_state_e;

  localparam logic [1:0] PC_HOLD   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ADV    = 2'd2;
  localparam logic [1:0] PC_LOAD   = 2'd3;

  warp_state_e               state_q [NUM_WARP];
  warp_state_e               state_d [NUM_WARP];
  logic [NUM_WARP-1:0]       pend_end_q, pend_end_d;
  logic [2*NUM_WARP-1:0]     pc_src_q, pc_src_d;
  logic [DEPTH_WARP-1:0]     rr_q, rr_d;

  logic [NUM_WARP-1:0]       ev_end, ev_init, ev_branch, ev_rsp, ev_grant, eligible;
  logic [DEPTH_WARP-1:0]     grant_wid, scan_idx;
  logic                      grant_any, accept;

  // Decode the per-warp event targets and fetch eligibility
  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      ev_end[w]    = end_valid_i    && (end_wid_i    == DEPTH_WARP'(w));
      ev_init[w]   = init_valid_i   && (init_wid_i   == DEPTH_WARP'(w));
      ev_branch[w] = branch_valid_i && (branch_wid_i == DEPTH_WARP'(w));
      ev_rsp[w]    = rsp_valid_i    && (rsp_wid_i    == DEPTH_WARP'(w));
      // A warp being redirected or retired this cycle must not fetch its stale PC
      eligible[w]  = (state_q[w] == S_RDY) && !stall_i[w] &&
                     !ev_end[w] && !ev_init[w] && !ev_branch[w];
    end
  end

  // Round-robin scan: first eligible warp at or after rr, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_wid = '0;
    scan_idx  = rr_q;
    for (int i = 0; i < NUM_WARP; i++) begin
      scan_idx = rr_q + DEPTH_WARP'(i);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_wid = scan_idx;
      end
    end
  end

  assign fetch_valid_o = grant_any;
  assign fetch_wid_o   = grant_wid;
  assign accept        = grant_any && fetch_ready_i;

  // Accepted grant decode and pointer advance
  always_comb begin
    rr_d = accept ? (grant_wid + DEPTH_WARP'(1)) : rr_q;
    for (int w = 0; w < NUM_WARP; w++) begin
      ev_grant[w] = accept && (grant_wid == DEPTH_WARP'(w));
    end
  end

  // Per-warp state transitions and PC-control code, priority end > init > branch > rsp > grant
  always_comb begin
    pc_src_d   = '0;
    pend_end_d = pend_end_q;
    for (int w = 0; w < NUM_WARP; w++) begin
      state_d[w] = state_q[w];
      case (state_q[w])
        S_OFF: begin
          if (!ev_end[w] && ev_init[w]) begin
            state_d[w] = S_UPD;
            pc_src_d[2*w +: 2] = PC_LOAD;
          end
        end
        S_RDY, S_UPD: begin
          if (ev_end[w]) begin
            state_d[w] = S_OFF;
          end else if (ev_init[w]) begin
            state_d[w] = S_UPD;
            pc_src_d[2*w +: 2] = PC_LOAD;
          end else if (ev_branch[w]) begin
            state_d[w] = S_UPD;
            pc_src_d[2*w +: 2] = PC_BRANCH;
          end else if (state_q[w] == S_UPD) begin
            state_d[w] = S_RDY;
          end else if (ev_grant[w]) begin
            state_d[w] = S_PEND;
          end
        end
        S_PEND, S_FLUSH: begin
          if (ev_rsp[w]) begin
            // The outstanding fetch retires this cycle; any redirect now goes straight to UPD
            if (ev_end[w] || pend_end_q[w]) begin
              state_d[w]    = S_OFF;
              pend_end_d[w] = 1'b0;
            end else if (ev_init[w]) begin
              state_d[w] = S_UPD;
              pc_src_d[2*w +: 2] = PC_LOAD;
            end else if (ev_branch[w]) begin
              state_d[w] = S_UPD;
              pc_src_d[2*w +: 2] = PC_BRANCH;
            end else if (state_q[w] == S_FLUSH) begin
              state_d[w] = S_RDY;
            end else begin
              state_d[w] = S_UPD;
              pc_src_d[2*w +: 2] = rsp_hit_i ? PC_ADV : PC_LOAD;
            end
          end else if (ev_end[w]) begin
            state_d[w]    = S_FLUSH;
            pend_end_d[w] = 1'b1;
          end else if (ev_init[w]) begin
            // Relaunch while a fetch is in flight cancels any recorded end
            state_d[w]    = S_FLUSH;
            pend_end_d[w] = 1'b0;
            pc_src_d[2*w +: 2] = PC_LOAD;
          end else if (ev_branch[w]) begin
            state_d[w] = S_FLUSH;
            if (!pend_end_q[w]) begin
              pc_src_d[2*w +: 2] = PC_BRANCH;
            end
          end
        end
        default: begin
          state_d[w]    = S_OFF;
          pend_end_d[w] = 1'b0;
        end
      endcase
    end
  end

  // State, pointer and registered PC-control codes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARP; w++) begin
        state_q[w] <= S_OFF;
      end
      pend_end_q <= '0;
      pc_src_q   <= '0;
      rr_q       <= '0;
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        state_q[w] <= state_d[w];
      end
      pend_end_q <= pend_end_d;
      pc_src_q   <= pc_src_d;
      rr_q       <= rr_d;
    end
  end

  assign pc_src_o = pc_src_q;

endmodule

// File: tb/tb_fetch_pc_sched.sv
// tb/tb_fetch_pc_sched.sv - self-checking bench for fetch_pc_sched
module tb_fetch_pc_sched;
  localparam int NW = 8;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_valid_i, end_valid_i, branch_valid_i, rsp_valid_i, rsp_hit_i;
  logic [DW-1:0] init_wid_i, end_wid_i, branch_wid_i, rsp_wid_i;
  logic [NW-1:0] stall_i;
  logic          fetch_valid_o, fetch_ready_i;
  logic [DW-1:0] fetch_wid_o;
  logic [2*NW-1:0] pc_src_o;

  always #5 clk = ~clk;

  fetch_pc_sched #(.NUM_WARP(NW), .DEPTH_WARP(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_valid_i(init_valid_i), .init_wid_i(init_wid_i),
    .end_valid_i(end_valid_i), .end_wid_i(end_wid_i),
    .branch_valid_i(branch_valid_i), .branch_wid_i(branch_wid_i),
    .stall_i(stall_i),
    .fetch_valid_o(fetch_valid_o), .fetch_wid_o(fetch_wid_o), .fetch_ready_i(fetch_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_wid_i(rsp_wid_i), .rsp_hit_i(rsp_hit_i),
    .pc_src_o(pc_src_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a warp is alive, may have one fetch in flight (possibly to be
  // discarded), may have an end recorded, or may be waiting one cycle for its PC update.
  bit m_active [NW];
  bit m_out    [NW];
  bit m_disc   [NW];
  bit m_ended  [NW];
  bit m_upd    [NW];
  int m_rr;
  logic [2*NW-1:0] m_pc;

  logic          s_valid;
  logic [DW-1:0] s_wid;
  logic [2*NW-1:0] s_pc;

  typedef struct {
    bit iv; bit [2:0] iw;
    bit ev; bit [2:0] ew;
    bit bv; bit [2:0] bw;
    bit rv; bit [2:0] rw; bit rh;
    bit rdy;
    bit xv; bit [2:0] xw; bit [15:0] xpc;
  } vec_t;

  vec_t tbl [14];
  int   order [$];
  int   c2 [NW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit targeted(input int w);
    return (init_valid_i && init_wid_i == 3'(w)) || (end_valid_i && end_wid_i == 3'(w)) ||
           (branch_valid_i && branch_wid_i == 3'(w));
  endfunction

  task automatic model_grant(output bit gv, output int gw);
    gv = 1'b0;
    gw = 0;
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (m_rr + k) % NW;
      if (!gv && m_active[w] && !m_upd[w] && !m_out[w] && !stall_i[w] && !targeted(w)) begin
        gv = 1'b1;
        gw = w;
      end
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_active[w] = 0; m_out[w] = 0; m_disc[w] = 0; m_ended[w] = 0; m_upd[w] = 0;
    end
    m_rr = 0;
    m_pc = '0;
  endtask

  task automatic model_step();
    bit gv, acc, e, i, b, r, g;
    int gw;
    logic [1:0] code;
    logic [2*NW-1:0] npc;
    model_grant(gv, gw);
    acc = gv && fetch_ready_i;
    npc = '0;
    for (int w = 0; w < NW; w++) begin
      e = end_valid_i && end_wid_i == 3'(w);
      i = init_valid_i && init_wid_i == 3'(w);
      b = branch_valid_i && branch_wid_i == 3'(w);
      r = rsp_valid_i && rsp_wid_i == 3'(w) && m_out[w];
      g = acc && gw == w;
      code = 2'd0;
      if (!m_out[w]) begin
        if (e) begin m_active[w] = 0; m_upd[w] = 0; end
        else if (i) begin m_active[w] = 1; m_upd[w] = 1; code = 2'd3; end
        else if (b && m_active[w]) begin m_upd[w] = 1; code = 2'd1; end
        else if (m_upd[w]) m_upd[w] = 0;
        else if (g) begin m_out[w] = 1; m_disc[w] = 0; end
      end else if (r) begin
        m_out[w] = 0;
        if (e || m_ended[w]) begin m_active[w] = 0; m_ended[w] = 0; m_upd[w] = 0; end
        else if (i) begin m_upd[w] = 1; code = 2'd3; end
        else if (b) begin m_upd[w] = 1; code = 2'd1; end
        else if (m_disc[w]) m_upd[w] = 0;
        else begin m_upd[w] = 1; code = rsp_hit_i ? 2'd2 : 2'd3; end
      end else begin
        if (e) begin m_ended[w] = 1; m_disc[w] = 1; end
        else if (i) begin m_ended[w] = 0; m_disc[w] = 1; code = 2'd3; end
        else if (b) begin m_disc[w] = 1; if (!m_ended[w]) code = 2'd1; end
      end
      npc[2*w +: 2] = code;
    end
    m_pc = npc;
    if (acc) m_rr = (gw + 1) % NW;
  endtask

  // One clock: sample and compare at the falling edge, advance the model, return after the rising edge
  task automatic cyc();
    bit gv;
    int gw;
    @(negedge clk);
    model_grant(gv, gw);
    s_valid = fetch_valid_o;
    s_wid   = fetch_wid_o;
    s_pc    = pc_src_o;
    check("model_fetch_valid", 32'(fetch_valid_o), 32'(gv));
    if (gv) check("model_fetch_wid", 32'(fetch_wid_o), 32'(gw));
    check("model_pc_src", 32'(pc_src_o), 32'(m_pc));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    init_valid_i = 0; end_valid_i = 0; branch_valid_i = 0; rsp_valid_i = 0;
    init_wid_i = 0; end_wid_i = 0; branch_wid_i = 0; rsp_wid_i = 0; rsp_hit_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    stall_i = '0;
    fetch_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_fetch_valid", 32'(fetch_valid_o), 32'd0);
    check("reset_fetch_wid", 32'(fetch_wid_o), 32'd0);
    check("reset_pc_src", 32'(pc_src_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic init_warp(input int w);
    idle();
    init_valid_i = 1'b1;
    init_wid_i = 3'(w);
    cyc();
    idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // iv iw ev ew bv bw rv rw rh rdy xv xw xpc
    tbl[0]  = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0030};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 16'h0000};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 16'h0000};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0020};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 16'h0000};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 16'h0000};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0030};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 16'h0000};
    tbl[9]  = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 16'h0000};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 16'h0010};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 16'h0000};
    tbl[12] = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};

    do_reset();
    for (int k = 0; k < 14; k++) begin
      init_valid_i = tbl[k].iv;   init_wid_i = tbl[k].iw;
      end_valid_i = tbl[k].ev;    end_wid_i = tbl[k].ew;
      branch_valid_i = tbl[k].bv; branch_wid_i = tbl[k].bw;
      rsp_valid_i = tbl[k].rv;    rsp_wid_i = tbl[k].rw; rsp_hit_i = tbl[k].rh;
      fetch_ready_i = tbl[k].rdy;
      cyc();
      check($sformatf("tbl_valid[%0d]", k), 32'(s_valid), 32'(tbl[k].xv));
      if (tbl[k].xv) check($sformatf("tbl_wid[%0d]", k), 32'(s_wid), 32'(tbl[k].xw));
      check($sformatf("tbl_pc[%0d]", k), 32'(s_pc), 32'(tbl[k].xpc));
    end

    // Fair arbitration across all eight warps with one-cycle hits
    do_reset();
    for (int w = 0; w < NW; w++) init_warp(w);
    repeat (2) cyc();
    begin
      bit pv;
      logic [2:0] pw;
      pv = 0;
      pw = 0;
      for (int c = 0; c < 12; c++) begin
        idle();
        fetch_ready_i = (c < 9);
        rsp_valid_i = pv;
        rsp_wid_i = pw;
        rsp_hit_i = 1'b1;
        cyc();
        for (int w = 0; w < NW; w++) if (s_pc[2*w +: 2] == 2'd2) c2[w]++;
        pv = s_valid && fetch_ready_i;
        pw = s_wid;
        if (pv) order.push_back(int'(s_wid));
      end
    end
    check("fair_grant_count", 32'(order.size()), 32'd9);
    for (int k = 0; k < order.size(); k++) check($sformatf("fair_order[%0d]", k), 32'(order[k]), 32'(k % NW));
    for (int w = 0; w < NW; w++) check($sformatf("fair_adv_codes[%0d]", w), 32'(c2[w]), (w == 0) ? 32'd2 : 32'd1);

    // Miss replay, then miss replay held off by stall
    do_reset();
    init_warp(1);
    fetch_ready_i = 0;
    cyc();
    fetch_ready_i = 1;
    cyc();
    check("miss_first_grant", 32'({s_valid, s_wid}), 32'({1'b1, 3'd1}));
    rsp_valid_i = 1; rsp_wid_i = 1; rsp_hit_i = 0;
    cyc();
    idle();
    check("miss_no_grant_in_rsp", 32'(s_valid), 32'd0);
    cyc();
    check("miss_code3", 32'(s_pc), 32'h000C);
    check("miss_no_grant_in_upd", 32'(s_valid), 32'd0);
    cyc();
    check("miss_regrant", 32'({s_valid, s_wid}), 32'({1'b1, 3'd1}));
    rsp_valid_i = 1; rsp_wid_i = 1; rsp_hit_i = 0;
    stall_i = 8'h02;
    cyc();
    idle();
    cyc();
    check("stall_miss_code3", 32'(s_pc), 32'h000C);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("stall_hold[%0d]", k), 32'(s_valid), 32'd0);
    end
    stall_i = 8'h00;
    cyc();
    check("stall_release_grant", 32'({s_valid, s_wid}), 32'({1'b1, 3'd1}));

    // Branch vs grant on warp 4, then end with response on pending warp 5
    do_reset();
    init_warp(4);
    init_warp(5);
    repeat (2) cyc();
    branch_valid_i = 1; branch_wid_i = 4; fetch_ready_i = 1;
    cyc();
    idle();
    check("branch_grant_other", 32'({s_valid, s_wid}), 32'({1'b1, 3'd5}));
    end_valid_i = 1; end_wid_i = 5; rsp_valid_i = 1; rsp_wid_i = 5; rsp_hit_i = 1;
    fetch_ready_i = 0;
    cyc();
    idle();
    check("branch_code1_w4", 32'(s_pc), 32'h0100);
    cyc();
    check("end_rsp_no_code", 32'(s_pc), 32'h0000);
    check("w4_ready_after_branch", 32'({s_valid, s_wid}), 32'({1'b1, 3'd4}));
    stall_i = 8'h10;
    cyc();
    check("w5_off", 32'(s_valid), 32'd0);
    stall_i = 8'h00;

    // Backpressure keeps rr; stall redirects; accept moves rr past 6
    do_reset();
    init_warp(0);
    init_warp(6);
    init_warp(7);
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("bp_hold[%0d]", k), 32'({s_valid, s_wid}), 32'({1'b1, 3'd0}));
    end
    stall_i = 8'h01;
    cyc();
    check("bp_stall_switch", 32'({s_valid, s_wid}), 32'({1'b1, 3'd6}));
    fetch_ready_i = 1;
    cyc();
    check("bp_accept6", 32'({s_valid, s_wid}), 32'({1'b1, 3'd6}));
    stall_i = 8'h00;
    fetch_ready_i = 0;
    cyc();
    check("bp_rr_is_7", 32'({s_valid, s_wid}), 32'({1'b1, 3'd7}));

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int outs [$];
      idle();
      init_valid_i = ($urandom_range(5, 0) == 0);
      init_wid_i = 3'($urandom_range(7, 0));
      end_valid_i = ($urandom_range(11, 0) == 0);
      end_wid_i = 3'($urandom_range(7, 0));
      branch_valid_i = ($urandom_range(5, 0) == 0);
      branch_wid_i = 3'($urandom_range(7, 0));
      fetch_ready_i = ($urandom_range(3, 0) != 0);
      stall_i = 8'($urandom & $urandom & $urandom);
      for (int w = 0; w < NW; w++) if (m_out[w]) outs.push_back(w);
      if (outs.size() > 0 && $urandom_range(1, 0) == 1) begin
        rsp_valid_i = 1;
        rsp_wid_i = 3'(outs[$urandom_range(outs.size() - 1, 0)]);
        rsp_hit_i = 1'($urandom_range(1, 0));
      end else if ($urandom_range(19, 0) == 0) begin
        rsp_valid_i = 1;
        rsp_wid_i = 3'($urandom_range(7, 0));
        rsp_hit_i = 1'($urandom_range(1, 0));
      end
      cyc();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sched.md
# fetch_pc_sched

Per-warp fetch sequencer and round-robin fetch arbiter for the warp scheduler. It tracks every warp's fetch state and grants one instruction-cache fetch per cycle among eligible warps. It drives the 2-bit `pc_src` code of each warp's PC-control register: 0 hold, 1 branch, 2 pipe advance, 3 replay/load. This guarantees that a warp's PC is never refetched before its PC update has landed.

## Interface
Parameters:
- `NUM_WARP`, 8: number of warps; must be a power of two, ≥2.
- `DEPTH_WARP`, 3: log2(`NUM_WARP`); width of warp IDs.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `init_valid_i` in 1: warp launch; its PC-control is to load the launch PC (code 3).
- `init_wid_i` in DEPTH_WARP: launched warp ID.
- `end_valid_i` in 1: warp finished.
- `end_wid_i` in DEPTH_WARP: finished warp ID.
- `branch_valid_i` in 1: taken branch/jump redirect from execute.
- `branch_wid_i` in DEPTH_WARP: redirected warp ID.
- `stall_i` in NUM_WARP: per-warp fetch inhibit (ibuffer full, barrier).
- `fetch_valid_o` out 1: fetch request valid.
- `fetch_wid_o` out DEPTH_WARP: granted warp ID.
- `fetch_ready_i` in 1: icache accepts request.
- `rsp_valid_i` in 1: icache response.
- `rsp_wid_i` in DEPTH_WARP: responding warp ID.
- `rsp_hit_i` in 1: 1 hit (advance), 0 miss (replay same PC).
- `pc_src_o` out 2*NUM_WARP: per-warp `pc_src`; warp w uses bits [2w+1:2w].

## Operation
- Per-warp state: OFF, RDY, UPD, PEND, FLUSH.
- Event priority for a warp in one cycle: end > init > branch > response > grant.
- **OFF**
  - init → UPD, code 3.
  - All other events ignored.
- **RDY**
  - end → OFF.
  - branch → UPD, code 1.
  - Grant accepted (`fetch_valid_o && fetch_ready_i`, wid = w) → PEND.
  - init → UPD, code 3.
- **UPD**
  - Lasts one cycle while the registered code reaches PC-control, then → RDY.
  - branch or init during UPD → stay UPD, with the new code 1 or 3 respectively.
  - end → OFF.
- **PEND**
  - Response hit → UPD, code 2.
  - Response miss → UPD, code 3 (external logic supplies the miss PC on `new_pc`).
  - branch → FLUSH, code 1.
  - end → FLUSH, with pending-end recorded.
- **FLUSH**
  - Waits for the outstanding response, which is discarded and produces no code.
  - On the response → OFF if the warp ended, else RDY.
  - branch during FLUSH → code 1, stay FLUSH.
  - end during FLUSH → record pending-end.
- A response to a warp not in PEND/FLUSH is a protocol error: ignored, no state change.
- At most one outstanding fetch per warp.
- `pc_src_o` is registered. All 2-bit codes default to 0 each cycle unless an event above sets them.
- **Eligible(w)**: state RDY, `!stall_i[w]`, and w is not the target of branch, init or end in the same cycle.
- **Arbitration**
  - Round-robin starting at pointer `rr`; the first eligible warp at index ≥ `rr` (wrapping modulo NUM_WARP) is granted.
  - `fetch_valid_o` = any eligible. Both `fetch_valid_o` and `fetch_wid_o` are combinational.
  - `rr` ← granted+1 (mod NUM_WARP) only on accept; otherwise `rr` holds.
  - `fetch_wid_o` may change while not accepted; no stability guarantee.

## Timing
- Reset: all warps OFF, `rr`=0, `pc_src_o`=0, `fetch_valid_o`=0, `fetch_wid_o`=0.
- Reset mid-operation discards outstanding fetches. The icache must also be reset.
- Event in cycle t → code on `pc_src_o` in cycle t+1 → PC updated at end of t+1 → warp eligible in t+2.
- Minimum per-warp refetch interval: accept at t, response at t+1, next grant at t+3.
- Grant is 0-latency: `fetch_valid_o` is valid in the same cycle the warp enters RDY.
- Throughput: one accepted fetch per cycle across warps.

## Test plan
- **Reset, then init**: init warp 2 at t → `pc_src_o[5:4]`=3 at t+1; `fetch_valid_o`=1, `fetch_wid_o`=2 at t+2.
- **Fair arbitration**: all 8 warps RDY, `fetch_ready_i`=1, hits after 1 cycle → grants in order 0,1,…,7,0. Each warp shows code 2 exactly once per grant.
- **Miss replay**: warp 1 granted, response miss → code 3 on warp 1 next cycle, then regrant of warp 1 two cycles later. Rerun with `stall_i[1]`=1 → no grant of warp 1 until stall drops.
- **Branch during PEND**: warp 3 accepted, branch warp 3 next cycle → code 1. A later hit response → no code 2, warp 3 returns to RDY.
- **Simultaneous events**:
  - branch and grant target warp 4 in the same cycle → warp 4 not granted, another eligible warp granted; warp 4 gets code 1.
  - end and response for PEND warp 5 in the same cycle → OFF, no code.
- **Backpressure**: `fetch_ready_i`=0 for 5 cycles with warps 0 and 6 RDY → `rr` unchanged. Raising `stall_i[0]` switches `fetch_wid_o` to 6. Accepting warp 6 → `rr`=7.
